// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the shared sudo_ALU.
// master = environment (requesters, consumer, ALU); slave = the arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 2
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [OP_W-1:0]       req0_opcode;
  logic [DATA_W-1:0]     req0_a;
  logic [DATA_W-1:0]     req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [OP_W-1:0]       req1_opcode;
  logic [DATA_W-1:0]     req1_a;
  logic [DATA_W-1:0]     req1_b;
  logic [OP_W-1:0]       alu_opcode;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2*DATA_W-1:0]   alu_y;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [2*DATA_W-1:0]   rsp_y;
  logic                  busy;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_y,
    input  rsp_valid, rsp_id, rsp_y, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_y,
    output rsp_valid, rsp_id, rsp_y, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight, tagged result returned over a valid/ready channel.
module alu_arbiter #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 2,
  parameter int EXEC_CYCLES = 1
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OP_W-1:0]       alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [2*DATA_W-1:0]   rsp_y_q, rsp_y_d;
  logic                  busy_q, busy_d;
  logic                  grant_valid;
  logic                  grant_id;

  // Grant is combinational and only offered in IDLE; the pointer breaks ties.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ptr_q;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_valid && !grant_id;
  assign bus.req1_ready = grant_valid &&  grant_id;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = EXEC;
          ptr_d        = ~grant_id;
          cnt_d        = CNT_LOAD;
          rsp_id_d     = grant_id;
          alu_opcode_d = grant_id ? bus.req1_opcode : bus.req0_opcode;
          alu_a_d      = grant_id ? bus.req1_a      : bus.req0_a;
          alu_b_d      = grant_id ? bus.req1_b      : bus.req0_b;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_y_d     = bus.alu_y;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Drives two arbiters (EXEC_CYCLES 1 and 3) with identical stimulus and checks
// every output each cycle against a transaction-level model, plus directed literal checks.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int YW = 2 * DW;
  localparam int EXEC_OF [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          r0_valid, r1_valid, rsp_ready;
  logic [OW-1:0] r0_op, r1_op;
  logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) if1 ();
  alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) if3 ();

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Reference sudo_ALU: 0 add, 1 mul, 2 dec a, 3 transfer b.
  function automatic logic [YW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'd0:    return YW'(a) + YW'(b);
      2'd1:    return YW'(a) * YW'(b);
      2'd2:    return YW'(a) - YW'(1);
      default: return YW'(b);
    endcase
  endfunction

  assign if1.req0_valid = r0_valid;  assign if3.req0_valid = r0_valid;
  assign if1.req0_opcode = r0_op;    assign if3.req0_opcode = r0_op;
  assign if1.req0_a = r0_a;          assign if3.req0_a = r0_a;
  assign if1.req0_b = r0_b;          assign if3.req0_b = r0_b;
  assign if1.req1_valid = r1_valid;  assign if3.req1_valid = r1_valid;
  assign if1.req1_opcode = r1_op;    assign if3.req1_opcode = r1_op;
  assign if1.req1_a = r1_a;          assign if3.req1_a = r1_a;
  assign if1.req1_b = r1_b;          assign if3.req1_b = r1_b;
  assign if1.rsp_ready = rsp_ready;  assign if3.rsp_ready = rsp_ready;
  assign if1.alu_y = alu_fn(if1.alu_opcode, if1.alu_a, if1.alu_b);
  assign if3.alu_y = alu_fn(if3.alu_opcode, if3.alu_a, if3.alu_b);

  logic          o_rdy0 [2], o_rdy1 [2], o_busy [2], o_rv [2], o_rid [2];
  logic [YW-1:0] o_ry [2];
  logic [OW-1:0] o_op [2];
  logic [DW-1:0] o_a [2], o_b [2];

  always_comb begin
    o_rdy0[0] = if1.req0_ready; o_rdy0[1] = if3.req0_ready;
    o_rdy1[0] = if1.req1_ready; o_rdy1[1] = if3.req1_ready;
    o_busy[0] = if1.busy;       o_busy[1] = if3.busy;
    o_rv[0]   = if1.rsp_valid;  o_rv[1]   = if3.rsp_valid;
    o_rid[0]  = if1.rsp_id;     o_rid[1]  = if3.rsp_id;
    o_ry[0]   = if1.rsp_y;      o_ry[1]   = if3.rsp_y;
    o_op[0]   = if1.alu_opcode; o_op[1]   = if3.alu_opcode;
    o_a[0]    = if1.alu_a;      o_a[1]    = if3.alu_a;
    o_b[0]    = if1.alu_b;      o_b[1]    = if3.alu_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op owns the unit until its result is
  // handed over; the result shows up EXEC_CYCLES edges after the accept edge.
  bit            m_busy [2]   = '{0, 0};
  bit            m_rv [2]     = '{0, 0};
  bit            m_ptr [2]    = '{0, 0};
  bit            m_rid [2]    = '{0, 0};
  int            m_wait [2]   = '{0, 0};
  logic [YW-1:0] m_ry [2]     = '{0, 0};
  logic [YW-1:0] m_res [2]    = '{0, 0};
  logic [OW-1:0] m_op [2]     = '{0, 0};
  logic [DW-1:0] m_a [2]      = '{0, 0};
  logic [DW-1:0] m_b [2]      = '{0, 0};

  function automatic bit m_winner(input int k);
    return (r0_valid && r1_valid) ? m_ptr[k] : r1_valid;
  endfunction

  always @(negedge clk) begin : compare
    for (int k = 0; k < 2; k++) begin
      bit offer;
      bit w;
      offer = !m_busy[k] && (r0_valid || r1_valid);
      w     = m_winner(k);
      check($sformatf("i%0d req0_ready", k), o_rdy0[k], offer && !w);
      check($sformatf("i%0d req1_ready", k), o_rdy1[k], offer && w);
      check($sformatf("i%0d busy", k),       o_busy[k], m_busy[k]);
      check($sformatf("i%0d rsp_valid", k),  o_rv[k],   m_rv[k]);
      check($sformatf("i%0d rsp_id", k),     o_rid[k],  m_rid[k]);
      check($sformatf("i%0d rsp_y", k),      o_ry[k],   m_ry[k]);
      check($sformatf("i%0d alu_opcode", k), o_op[k],   m_op[k]);
      check($sformatf("i%0d alu_a", k),      o_a[k],    m_a[k]);
      check($sformatf("i%0d alu_b", k),      o_b[k],    m_b[k]);
      // Advance the model to what the next rising edge will produce.
      if (!rst_n) begin
        m_busy[k] = 0; m_rv[k] = 0; m_ptr[k] = 0; m_rid[k] = 0; m_wait[k] = 0;
        m_ry[k] = '0; m_res[k] = '0; m_op[k] = '0; m_a[k] = '0; m_b[k] = '0;
      end else if (offer) begin
        m_op[k]   = w ? r1_op : r0_op;
        m_a[k]    = w ? r1_a  : r0_a;
        m_b[k]    = w ? r1_b  : r0_b;
        m_rid[k]  = w;
        m_ptr[k]  = !w;
        m_res[k]  = alu_fn(m_op[k], m_a[k], m_b[k]);
        m_wait[k] = EXEC_OF[k];
        m_busy[k] = 1;
      end else if (m_busy[k] && !m_rv[k]) begin
        m_wait[k]--;
        if (m_wait[k] == 0) begin
          m_rv[k] = 1;
          m_ry[k] = m_res[k];
        end
      end else if (m_rv[k] && rsp_ready) begin
        m_rv[k]   = 0;
        m_busy[k] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    clear_reqs();
    rsp_ready = 1;
    n = 0;
    while ((o_busy[0] || o_busy[1]) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle timeout", 32'd0, 32'd1);
  endtask

  // Single op on instance k; edges are counted from the cycle the grant is offered.
  task automatic run_op(input int k, input bit id, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [YW-1:0] exp_y, input int exp_edges);
    int n;
    clear_reqs();
    rsp_ready = 1;
    if (id) begin r1_valid = 1; r1_op = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1; r0_op = op; r0_a = a; r0_b = b; end
    #1;
    check($sformatf("op%0d busy before", k), o_busy[k], 0);
    check($sformatf("op%0d ready granted", k), id ? o_rdy1[k] : o_rdy0[k], 1);
    check($sformatf("op%0d ready other", k), id ? o_rdy0[k] : o_rdy1[k], 0);
    n = 0;
    do begin
      tick();
      n++;
      clear_reqs();
      if (!o_rv[k]) check($sformatf("op%0d busy in flight", k), o_busy[k], 1);
    end while (!o_rv[k] && n < 20);
    check($sformatf("op%0d latency", k), n, exp_edges);
    check($sformatf("op%0d rsp_id", k), o_rid[k], id);
    check($sformatf("op%0d rsp_y", k), o_ry[k], exp_y);
    check($sformatf("op%0d busy at rsp", k), o_busy[k], 1);
    tick();
    check($sformatf("op%0d rsp_valid after", k), o_rv[k], 0);
    check($sformatf("op%0d busy after", k), o_busy[k], 0);
    wait_idle();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int grants [4];
    int g;
    int n;
    rst_n = 0; rsp_ready = 0;
    r0_valid = 0; r1_valid = 0; r0_op = '0; r1_op = '0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    tick(); tick();
    rst_n = 1;
    wait_idle();

    // Plain ops with hand-computed results.
    run_op(0, 1'b0, 2'd0, 8'd100, 8'd200, 16'd300, 2);
    run_op(0, 1'b1, 2'd1, 8'd255, 8'd255, 16'd65025, 2);
    run_op(1, 1'b0, 2'd2, 8'd10, 8'd0, 16'd9, 4);

    // Tie held for four ops after reset: grants alternate from requester 0.
    rst_n = 0; tick(); rst_n = 1;
    r0_valid = 1; r1_valid = 1; r0_op = 2'd0; r1_op = 2'd3;
    r0_a = 8'd1; r0_b = 8'd2; r1_a = 8'd3; r1_b = 8'd4;
    rsp_ready = 1;
    #1;
    g = 0; n = 0;
    while (g < 4 && n < 40) begin
      if (o_rdy0[0] || o_rdy1[0]) begin
        grants[g] = o_rdy1[0] ? 1 : 0;
        g++;
      end
      tick();
      n++;
    end
    check("tie grant count", g, 4);
    check("tie grant0", grants[0], 0);
    check("tie grant1", grants[1], 1);
    check("tie grant2", grants[2], 0);
    check("tie grant3", grants[3], 1);
    wait_idle();

    // Backpressure: response held stable while rsp_ready is low.
    rsp_ready = 0;
    r1_valid = 1; r1_op = 2'd3; r1_a = 8'h5A; r1_b = 8'hAB;
    #1;
    check("bp ready1", o_rdy1[0], 1);
    n = 0;
    do begin
      tick();
      n++;
      r0_valid = 1; r1_valid = 1; r0_op = 2'd1; r1_op = 2'd0;
    end while (!o_rv[0] && n < 20);
    check("bp latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp rsp_valid", o_rv[0], 1);
      check("bp rsp_id", o_rid[0], 1);
      check("bp rsp_y", o_ry[0], 16'h00AB);
      check("bp ready0", o_rdy0[0], 0);
      check("bp ready1 held", o_rdy1[0], 0);
    end
    clear_reqs();
    rsp_ready = 1;
    tick();
    check("bp rsp_valid drop", o_rv[0], 0);
    wait_idle();

    // Reset in the middle of an op drops it without a response.
    r0_valid = 1; r0_op = 2'd0; r0_a = 8'd1; r0_b = 8'd2;
    tick();
    clear_reqs();
    check("rst busy pre", o_busy[0], 1);
    rst_n = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst i%0d busy", k), o_busy[k], 0);
      check($sformatf("rst i%0d rsp_valid", k), o_rv[k], 0);
      check($sformatf("rst i%0d rsp_y", k), o_ry[k], 0);
      check($sformatf("rst i%0d alu_a", k), o_a[k], 0);
      check($sformatf("rst i%0d alu_b", k), o_b[k], 0);
    end
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst no response", o_rv[0] | o_rv[1], 0);
    end
    r0_valid = 1; r1_valid = 1;
    #1;
    check("rst tie ready0", o_rdy0[0] & o_rdy0[1], 1);
    check("rst tie ready1", o_rdy1[0] | o_rdy1[1], 0);
    tick();
    wait_idle();

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      r0_valid  = $urandom_range(0, 1) == 1;
      r1_valid  = $urandom_range(0, 1) == 1;
      r0_op     = OW'($urandom_range(0, 3));
      r1_op     = OW'($urandom_range(0, 3));
      r0_a      = DW'($urandom);
      r0_b      = DW'($urandom);
      r1_a      = DW'($urandom);
      r1_b      = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
